mem_loader: RTL and testbench

- Write-side master for the single-port-write / async-read data memory.
- Accepts a byte stream over a valid/ready handshake and packs it into DATA_WIDTH words.
- Writes the words to consecutive memory addresses from a programmable base, then reads the same range back and checks it with a checksum.
- Used to preload program and data images before the pipeline is released from reset, and to bulk-load data from a host link.

---
 rtl/mem_loader.sv | 146 ++++++++++++++
 tb/tb_mem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Byte-stream loader: packs bytes into words, writes them from a base address,
// then reads the range back and compares read and write checksums.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_loader #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    localparam int BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH-1:0] word_idx_reg;
    logic [BW-1:0]         byte_idx_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [DATA_WIDTH-1:0] wsum_reg;
    logic [DATA_WIDTH-1:0] rsum_reg;
    logic                  error_reg;
    logic [ADDR_WIDTH-1:0] write_addr_reg;
    logic [DATA_WIDTH-1:0] write_data_reg;

    logic [DATA_WIDTH-1:0] filled_word;
    logic [DATA_WIDTH-1:0] rsum_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  last_word;
    logic                  last_byte;

    // Drop the incoming byte into its little-endian lane of the partial word.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign filled_word[8*gi +: 8] = (byte_idx_reg == BW'(gi)) ? s_data
                                                                      : word_reg[8*gi +: 8];
        end
    endgenerate

    assign cur_addr  = base_reg + word_idx_reg;
    assign last_word = ({1'b0, word_idx_reg} == (count_reg - 1'b1));
    assign last_byte = (byte_idx_reg == BW'(BYTES - 1));
    assign rsum_next = rsum_reg + mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            base_reg       <= '0;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            wsum_reg       <= '0;
            rsum_reg       <= '0;
            error_reg      <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        base_reg     <= base_addr;
                        count_reg    <= word_count;
                        error_reg    <= 1'b0;
                        word_idx_reg <= '0;
                        byte_idx_reg <= '0;
                        word_reg     <= '0;
                        wsum_reg     <= '0;
                        rsum_reg     <= '0;
                        state_reg    <= (word_count != '0) ? S_FILL : S_DONE;
                    end
                end
                S_FILL: begin
                    if (s_valid) begin
                        word_reg <= filled_word;
                        if (last_byte) begin
                            byte_idx_reg   <= '0;
                            write_addr_reg <= cur_addr;
                            write_data_reg <= filled_word;
                            state_reg      <= S_WRITE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    wsum_reg <= wsum_reg + write_data_reg;
                    if (last_word) begin
                        word_idx_reg <= '0;
                        state_reg    <= S_VERIFY;
                    end else begin
                        word_idx_reg <= word_idx_reg + 1'b1;
                        state_reg    <= S_FILL;
                    end
                end
                S_VERIFY: begin
                    rsum_reg <= rsum_next;
                    if (last_word) begin
                        error_reg <= (rsum_next != wsum_reg);
                        state_reg <= S_DONE;
                    end else begin
                        word_idx_reg <= word_idx_reg + 1'b1;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign s_ready           = (state_reg == S_FILL);
    assign mem_write_en      = (state_reg == S_WRITE);
    assign mem_write_address = write_addr_reg;
    assign mem_data_in       = write_data_reg;
    assign mem_read_address  = (state_reg == S_VERIFY) ? cur_addr : '0;
    assign busy              = (state_reg != S_IDLE);
    assign done              = (state_reg == S_DONE);
    assign error             = error_reg;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural async-read memory attached.
module tb_mem_loader;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_data_out;
    logic          busy;
    logic          done;
    logic          error;

    logic [DW-1:0] mem [256];
    logic          mem_init = 1'b0;
    logic          corrupt_en = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_err = 1'b0;
    int   write_cnt = 0;
    int   ready_cnt = 0;
    int   overlap_cnt = 0;

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
        .mem_data_in(mem_data_in), .mem_read_address(mem_read_address),
        .mem_data_out(mem_data_out), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_read_address];

    // Memory model; corrupt_en makes writes to 0x10 land as zero.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'hC300;
        end else if (mem_write_en) begin
            mem[mem_write_address] <= (corrupt_en && mem_write_address == 8'h10) ? '0 : mem_data_in;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= error;
        end
        if (mem_write_en) write_cnt <= write_cnt + 1;
        if (s_ready) ready_cnt <= ready_cnt + 1;
        if (mem_write_en && s_ready) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic do_load(input logic [AW-1:0] b, input logic [AW:0] n, input logic [7:0] bv [8],
                           input int gap, input bit repulse, output int lat, output logic err);
        int dc0, sc0, guard;
        logic acc;
        @(negedge clk); #1;
        dc0 = done_cnt;
        sc0 = cyc;
        base_addr = b; word_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = 8'h55; word_count = 9'd3;
        for (int i = 0; i < int'(n) * 2; i++) begin
            s_valid = 1'b1; s_data = bv[i]; acc = 1'b0; guard = 0;
            while (!acc && guard < 100) begin
                acc = s_ready;
                @(negedge clk);
                guard++;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL byte_accept: byte %0d got no s_ready within %0d cycles", i, guard);
            end
            s_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (repulse && i == 1 && g == 0) begin
                    start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        guard = 0;
        while (done_cnt == dc0 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (done_cnt == dc0) begin
            total++; bad++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", guard);
            lat = -1;
        end else begin
            lat = done_cyc - sc0;
        end
        err = done_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        total++;
        if ({s_ready, mem_write_en, busy, done, error} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {s_ready, mem_write_en, busy, done, error});
        end
        total++;
        if ({mem_write_address, mem_data_in, mem_read_address} !== '0) begin
            bad++; $display("FAIL reset_buses: got %h/%h/%h want 0", mem_write_address, mem_data_in, mem_read_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bv [8];
        int lat, w0;
        logic err;
        bv = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h0, 8'h0, 8'h0, 8'h0};
        w0 = write_cnt;
        do_load(8'h10, 9'd2, bv, 0, 1'b0, lat, err);
        total++;
        if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL basic_mem10: got %h want 1234", mem[8'h10]); end
        total++;
        if (mem[8'h11] !== 16'h5678) begin bad++; $display("FAIL basic_mem11: got %h want 5678", mem[8'h11]); end
        total++;
        if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", err); end
        total++;
        if (write_cnt - w0 !== 2) begin bad++; $display("FAIL basic_writes: got %0d want 2", write_cnt - w0); end
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] bv [8];
        logic [DW-1:0] snap [256];
        int lat, diffs;
        logic err;
        bv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0, 8'h0, 8'h0, 8'h0};
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        do_load(8'hFF, 9'd2, bv, 0, 1'b0, lat, err);
        total++;
        if (mem[8'hFF] !== 16'hBBAA) begin bad++; $display("FAIL wrap_memff: got %h want bbaa", mem[8'hFF]); end
        total++;
        if (mem[8'h00] !== 16'hDDCC) begin bad++; $display("FAIL wrap_mem00: got %h want ddcc", mem[8'h00]); end
        diffs = 0;
        for (int i = 1; i < 255; i++) if (mem[i] !== snap[i]) diffs++;
        total++;
        if (diffs !== 0) begin bad++; $display("FAIL wrap_others: got %0d changed want 0", diffs); end
        total++;
        if (lat !== 9 || err !== 1'b0) begin bad++; $display("FAIL wrap_done: got lat %0d err %b want 9 0", lat, err); end
    endtask

    task automatic test_zero();
        logic [7:0] bv [8];
        int lat, w0, r0;
        logic err;
        bv = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        w0 = write_cnt; r0 = ready_cnt;
        do_load(8'h40, 9'd0, bv, 0, 1'b0, lat, err);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
        total++;
        if (write_cnt - w0 !== 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", write_cnt - w0); end
        total++;
        if (ready_cnt - r0 !== 0) begin bad++; $display("FAIL zero_ready: got %0d want 0", ready_cnt - r0); end
    endtask

    task automatic test_corrupt();
        logic [7:0] bv [8];
        int lat;
        logic err;
        bv = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h0, 8'h0, 8'h0, 8'h0};
        corrupt_en = 1'b1;
        do_load(8'h10, 9'd2, bv, 0, 1'b0, lat, err);
        corrupt_en = 1'b0;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL corrupt_error: got %b want 1", err); end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL corrupt_hold: got %b want 1", error); end
        start = 1'b1; word_count = 9'd0; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if ({error, done} !== 2'b01) begin bad++; $display("FAIL corrupt_clear: got err,done=%b want 01", {error, done}); end
    endtask

    task automatic test_throttle();
        logic [7:0] bv [8];
        int lat, w0, o0;
        logic err;
        bv = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h0, 8'h0, 8'h0, 8'h0};
        w0 = write_cnt; o0 = overlap_cnt;
        do_load(8'h10, 9'd2, bv, 3, 1'b1, lat, err);
        total++;
        if (mem[8'h10] !== 16'h1234 || mem[8'h11] !== 16'h5678) begin
            bad++; $display("FAIL throttle_mem: got %h %h want 1234 5678", mem[8'h10], mem[8'h11]);
        end
        total++;
        if (overlap_cnt - o0 !== 0) begin bad++; $display("FAIL throttle_ready_in_write: got %0d want 0", overlap_cnt - o0); end
        total++;
        if (write_cnt - w0 !== 2) begin bad++; $display("FAIL throttle_writes: got %0d want 2", write_cnt - w0); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL throttle_error: got %b want 0", err); end
        total++;
        if (mem[8'h80] !== 16'hC380) begin bad++; $display("FAIL throttle_restart: mem80 got %h want c380", mem[8'h80]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bv [8];
        int lat, guard;
        logic acc, err;
        @(negedge clk);
        base_addr = 8'h20; word_count = 9'd1; start = 1'b1;
        s_valid = 1'b1; s_data = 8'h11;
        @(negedge clk);
        start = 1'b0;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 20) begin
            acc = s_ready;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, mem_write_en, busy, done, error} !== 5'b0 || acc !== 1'b1) begin
            bad++; $display("FAIL midreset_flags: got %b acc %b want 00000 acc 1",
                            {s_ready, mem_write_en, busy, done, error}, acc);
        end
        total++;
        if ({mem_write_address, mem_data_in} !== '0) begin
            bad++; $display("FAIL midreset_buses: got %h/%h want 0", mem_write_address, mem_data_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (mem[8'h20] !== 16'hC320) begin bad++; $display("FAIL midreset_mem20: got %h want c320", mem[8'h20]); end
        bv = '{8'hEF, 8'hBE, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        do_load(8'h20, 9'd1, bv, 0, 1'b0, lat, err);
        total++;
        if (mem[8'h20] !== 16'hBEEF) begin bad++; $display("FAIL reload_mem20: got %h want beef", mem[8'h20]); end
        total++;
        if (lat !== 5 || err !== 1'b0) begin bad++; $display("FAIL reload_done: got lat %0d err %b want 5 0", lat, err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_corrupt();
        test_throttle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
